// File: rtl/core_pkg.sv
// core_pkg: shared core definitions (XLEN, reset/trap vectors, branch FSM states, ALU operator codes)
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VEC_DEF = 32'h0000_0100;
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_t;
  function automatic logic misaligned(input logic [XLEN-1:0] a);
    return |a[1:0];
  endfunction
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: redirect select (jalr > jal > taken branch) and target adders; in pc/rs1/imm/flags, out redirect/target/misalign
module pc_target_calc
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic            comparison,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            misalign
);
  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] reg_rel;
  assign pc_rel = pc + imm;
  assign reg_rel = (rs1 + imm) & ~32'h1;
  assign redirect = jalr | jal | (branch & comparison);
  assign target = jalr ? reg_rel : pc_rel;
  assign misalign = redirect & misaligned(target);
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: pc register + RUN/HOLD/FLUSH branch FSM; in clk/rst/stall/instr_valid/branch/jal/jalr/comparison/imm/rs1, out pc/link/flush/trap; MISALIGN_TRAP_EN enables trap
module pc_branch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            instr_valid,
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic            comparison,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link,
  output logic            flush,
  output logic            trap
);
`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [XLEN-1:0] pc_n, target;
  logic redirect, misalign, advance, commit, trap_take, trap_n;
  pc_target_calc u_calc (
    .pc(pc),
    .rs1(rs1),
    .imm(imm),
    .branch(branch),
    .jal(jal),
    .jalr(jalr),
    .comparison(comparison),
    .redirect(redirect),
    .target(target),
    .misalign(misalign)
  );
  assign link = pc + 32'd4;
  assign flush = state == FLUSH;
  assign advance = instr_valid & ~stall & (state != FLUSH);
  // a released HOLD only re-presents the instruction; it commits on the next RUN cycle
  assign commit = advance & (state == RUN);
  assign trap_take = TRAP_EN & misalign;
  always_comb begin
    state_n = stall ? ((state == RUN) ? HOLD : state) : ((commit & redirect) ? FLUSH : RUN);
    pc_n = commit ? (redirect ? (trap_take ? TRAP_VEC : target) : pc + 32'd4) : pc;
    trap_n = commit & redirect & trap_take;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      trap <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      trap <= trap_n;
    end
  end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed scoreboard bench for pc_branch_unit
module tb_pc_branch_unit;
  logic clk = 1'b0;
  logic rst, stall, instr_valid, branch, jal, jalr, comparison;
  logic [31:0] imm, rs1, pc, link;
  logic flush, trap;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string tag;
    logic [31:0] pc;
    logic flush;
    logic trap;
  } exp_t;
  exp_t sb[$];
  pc_branch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .instr_valid(instr_valid),
    .branch(branch),
    .jal(jal),
    .jalr(jalr),
    .comparison(comparison),
    .imm(imm),
    .rs1(rs1),
    .pc(pc),
    .link(link),
    .flush(flush),
    .trap(trap)
  );
  always #5 clk = ~clk;
  task automatic step(input string tag, input logic r, iv, st, br, cmp, jl, jr,
                      input logic [31:0] im, r1, ep, input logic ef, et);
    exp_t e;
    rst = r;
    instr_valid = iv;
    stall = st;
    branch = br;
    comparison = cmp;
    jal = jl;
    jalr = jr;
    imm = im;
    rs1 = r1;
    sb.push_back('{tag, ep, ef, et});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    assert (pc === e.pc) else begin
      miscompares++;
      $error("FAIL %s pc observed %h expected %h", e.tag, pc, e.pc);
    end
    vectors++;
    assert (flush === e.flush) else begin
      miscompares++;
      $error("FAIL %s flush observed %b expected %b", e.tag, flush, e.flush);
    end
    vectors++;
    assert (trap === e.trap) else begin
      miscompares++;
      $error("FAIL %s trap observed %b expected %b", e.tag, trap, e.trap);
    end
    vectors++;
    assert (link === e.pc + 32'd4) else begin
      miscompares++;
      $error("FAIL %s link observed %h expected %h", e.tag, link, e.pc + 32'd4);
    end
  endtask
  initial begin
    rst = 1'b1;
    {stall, instr_valid, branch, jal, jalr, comparison} = '0;
    imm = '0;
    rs1 = '0;
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step("rst1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 16; i++)
      step("seq", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'(4 * i), 0, 0);
    step("br_taken", 0, 1, 0, 1, 1, 0, 0, 32'hFFFF_FFF8, 0, 32'h38, 1, 0);
    step("flush_ignore", 0, 1, 0, 1, 1, 0, 0, 32'h100, 0, 32'h38, 0, 0);
    step("after_flush", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h3C, 0, 0);
    step("seq40", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    step("br_not", 0, 1, 0, 1, 0, 0, 0, 32'h100, 0, 32'h44, 0, 0);
    step("stall_redir", 0, 1, 1, 0, 0, 1, 1, 32'h4, 32'h1001, 32'h44, 0, 0);
    step("hold_release", 0, 1, 0, 0, 0, 1, 1, 32'h4, 32'h1001, 32'h44, 0, 0);
    step("jalr_wins", 0, 1, 0, 0, 0, 1, 1, 32'h4, 32'h1001, 32'h1004, 1, 0);
    step("flush_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1004, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1004, 0, 0);
    step("jal_hi", 0, 1, 0, 0, 0, 1, 0, 32'hFFFF_EFF8, 0, 32'hFFFF_FFFC, 1, 0);
    step("flush_stall", 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
    step("flush_rel", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    step("wrap", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step("jal_20", 0, 1, 0, 0, 0, 1, 0, 32'h20, 0, 32'h20, 1, 0);
    step("rst_flush", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    step("jal_mis", 0, 1, 0, 0, 0, 1, 0, 32'h2, 0, 32'h100, 1, 1);
    step("trap_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0);
`else
    step("jal_mis", 0, 1, 0, 0, 0, 1, 0, 32'h2, 0, 32'h2, 1, 0);
    step("trap_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
